// File: rtl/udp_rx.sv
// udp_rx: GMII UDP/IPv4 receive parser; strips preamble/Ethernet/IPv4/UDP headers and streams the payload.
// Optional IPv4 header checksum check: define UDP_RX_IP_CSUM_EN.
module udp_rx #(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        rec_en,
    output logic [7:0]  rec_data,
    output logic        rec_pkt_done,
    output logic [15:0] rec_byte_num,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_PREAMBLE, ST_ETH_HEAD, ST_IP_HEAD, ST_UDP_HEAD, ST_RX_DATA, ST_RX_END
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] udp_len;
    logic [15:0] pay_len;
    logic [39:0] hdr;
    logic [47:0] mac_sh;
    logic [31:0] ip_sh;
    logic        done_pend;
    logic [47:0] win48;
    logic [31:0] win32;
    logic [15:0] win16;
    logic        ip_ok;

    // Sliding window of the most recent header bytes, current byte in the LSBs
    assign win48 = {hdr, gmii_rxd};
    assign win32 = win48[31:0];
    assign win16 = win48[15:0];

`ifdef UDP_RX_IP_CSUM_EN
    logic [15:0] csum;
    logic [16:0] csum_raw;
    logic [15:0] csum_nxt;

    assign csum_raw = {1'b0, csum} + {1'b0, win16};
    assign csum_nxt = csum_raw[15:0] + {15'd0, csum_raw[16]};
    assign ip_ok    = (win32 == BOARD_IP) && (csum_nxt == 16'hffff);

    // End-around-carry sum over the ten 16-bit header words, one word per odd byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            csum <= 16'd0;
        else if (state == ST_ETH_HEAD)
            csum <= 16'd0;
        else if (state == ST_IP_HEAD && gmii_rx_dv && cnt[0])
            csum <= csum_nxt;
    end
`else
    assign ip_ok = (win32 == BOARD_IP);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= 16'd0;
            udp_len      <= 16'd0;
            pay_len      <= 16'd0;
            hdr          <= 40'd0;
            mac_sh       <= 48'd0;
            ip_sh        <= 32'd0;
            done_pend    <= 1'b0;
            rec_en       <= 1'b0;
            rec_data     <= 8'd0;
            rec_pkt_done <= 1'b0;
            rec_byte_num <= 16'd0;
            src_mac      <= 48'd0;
            src_ip       <= 32'd0;
        end else begin
            rec_en       <= 1'b0;
            rec_pkt_done <= done_pend;
            done_pend    <= 1'b0;
            if (done_pend) begin
                rec_byte_num <= pay_len;
                src_mac      <= mac_sh;
                src_ip       <= ip_sh;
            end
            hdr <= {hdr[31:0], gmii_rxd};
            cnt <= cnt + 16'd1;
            if (!gmii_rx_dv) begin
                state <= ST_IDLE;
                cnt   <= 16'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= (gmii_rxd == 8'h55) ? ST_PREAMBLE : ST_RX_END;
                        cnt   <= 16'd1;
                    end
                    ST_PREAMBLE: begin
                        if (gmii_rxd == 8'hd5 && cnt == 16'd7) begin
                            state <= ST_ETH_HEAD;
                            cnt   <= 16'd0;
                        end else if (gmii_rxd != 8'h55 || cnt >= 16'd7) begin
                            state <= ST_RX_END;
                        end
                    end
                    ST_ETH_HEAD: begin
                        if (cnt == 16'd5 && win48 != BOARD_MAC && win48 != '1)
                            state <= ST_RX_END;
                        if (cnt == 16'd11)
                            mac_sh <= win48;
                        if (cnt == 16'd13) begin
                            state <= (win16 == 16'h0800) ? ST_IP_HEAD : ST_RX_END;
                            cnt   <= 16'd0;
                        end
                    end
                    ST_IP_HEAD: begin
                        if ((cnt == 16'd0 && gmii_rxd != 8'h45) || (cnt == 16'd9 && gmii_rxd != 8'd17))
                            state <= ST_RX_END;
                        if (cnt == 16'd15)
                            ip_sh <= win32;
                        if (cnt == 16'd19) begin
                            state <= ip_ok ? ST_UDP_HEAD : ST_RX_END;
                            cnt   <= 16'd0;
                        end
                    end
                    ST_UDP_HEAD: begin
                        if (cnt == 16'd5)
                            udp_len <= win16;
                        if (cnt == 16'd7) begin
                            pay_len   <= udp_len - 16'd8;
                            cnt       <= 16'd0;
                            state     <= (udp_len > 16'd8) ? ST_RX_DATA : ST_RX_END;
                            done_pend <= (udp_len == 16'd8);
                        end
                    end
                    ST_RX_DATA: begin
                        rec_en   <= 1'b1;
                        rec_data <= gmii_rxd;
                        if (cnt == pay_len - 16'd1) begin
                            done_pend <= 1'b1;
                            state     <= ST_RX_END;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_udp_rx.sv
// tb_udp_rx: table-driven and randomized frame-level checks of udp_rx against a frame-level reference model.
module tb_udp_rx;
    localparam logic [47:0] BMAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] BIP  = {8'd192, 8'd168, 8'd1, 8'd10};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dv = 1'b0;
    logic [7:0]  rxd = 8'd0;
    logic        rec_en;
    logic [7:0]  rec_data;
    logic        rec_pkt_done;
    logic [15:0] rec_byte_num;
    logic [47:0] src_mac;
    logic [31:0] src_ip;

    udp_rx dut (
        .clk(clk), .rst_n(rst_n), .gmii_rx_dv(dv), .gmii_rxd(rxd),
        .rec_en(rec_en), .rec_data(rec_data), .rec_pkt_done(rec_pkt_done),
        .rec_byte_num(rec_byte_num), .src_mac(src_mac), .src_ip(src_ip)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic [47:0] dmac;
        logic [15:0] etype;
        logic [7:0]  proto;
        logic [31:0] dip;
        logic [15:0] ulen;
        int          npay;
        int          cut;
        bit          bad_csum;
        bit          seq;
        int          exp_en;
        bit          exp_done;
        logic [15:0] exp_num;
    } vec_t;

    int          errs = 0;
    int          checks = 0;
    logic [7:0]  frm[$];
    logic [7:0]  pay[$];
    logic [7:0]  got_q[$];
    int          done_n = 0;
    logic [15:0] last_num = 16'd0;
    logic [47:0] exp_smac = 48'd0;
    logic [31:0] exp_sip = 32'd0;
    vec_t        tbl[13];

    always @(negedge clk) begin
        if (rec_en) got_q.push_back(rec_data);
        if (rec_pkt_done) done_n++;
    end

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s #%0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [15:0] ip_csum(input logic [7:0] h[20]);
        int s = 0;
        for (int i = 0; i < 10; i++) s += int'({h[2*i], h[2*i+1]});
        while (s > 32'hffff) s = (s & 32'hffff) + (s >> 16);
        return ~s[15:0];
    endfunction

    // Reference: a frame is delivered when every header rule holds; P payload bytes, fewer if truncated
    function automatic void model(inout vec_t v);
        bit acc;
        int p, avail;
        acc = (v.dmac == BMAC || v.dmac == 48'hffff_ffff_ffff) && v.etype == 16'h0800 &&
              v.proto == 8'd17 && v.dip == BIP && v.ulen >= 16'd8;
`ifdef UDP_RX_IP_CSUM_EN
        acc = acc && !v.bad_csum;
`endif
        p = int'(v.ulen) - 8;
        avail = (v.cut >= 0) ? v.cut : v.npay;
        v.exp_en   = acc ? ((avail < p) ? avail : p) : 0;
        v.exp_done = acc && avail >= p;
        v.exp_num  = v.exp_done ? v.ulen - 16'd8 : last_num;
    endfunction

    task automatic build(input vec_t v, input logic [47:0] smac, input logic [31:0] sip);
        logic [7:0]  h[20];
        logic [15:0] tl, cs;
        logic [7:0]  b;
        frm.delete();
        pay.delete();
        repeat (7) frm.push_back(8'h55);
        frm.push_back(8'hd5);
        for (int i = 0; i < 6; i++) frm.push_back(v.dmac[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(smac[47-8*i -: 8]);
        frm.push_back(v.etype[15:8]);
        frm.push_back(v.etype[7:0]);
        tl = 16'd20 + v.ulen;
        h = '{8'h45, 8'h00, tl[15:8], tl[7:0], 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, v.proto,
              8'h00, 8'h00, sip[31:24], sip[23:16], sip[15:8], sip[7:0],
              v.dip[31:24], v.dip[23:16], v.dip[15:8], v.dip[7:0]};
        cs = v.bad_csum ? 16'h0000 : ip_csum(h);
        h[10] = cs[15:8];
        h[11] = cs[7:0];
        for (int i = 0; i < 20; i++) frm.push_back(h[i]);
        frm.push_back(8'h04); frm.push_back(8'hd2); frm.push_back(8'h04); frm.push_back(8'hd2);
        frm.push_back(v.ulen[15:8]); frm.push_back(v.ulen[7:0]);
        frm.push_back(8'h00); frm.push_back(8'h00);
        for (int i = 0; i < v.npay; i++) begin
            b = v.seq ? 8'(8'h33 + 8'h11 * i) : 8'($urandom);
            pay.push_back(b);
            frm.push_back(b);
        end
        if (v.cut < 0) repeat (4) frm.push_back(8'($urandom));
        else while (frm.size() > 50 + v.cut) void'(frm.pop_back());
    endtask

    // Drives the frame one byte per cycle; optional one-cycle dv gap and latency probes around the payload
    task automatic send(input int gap_at, input bit timed);
        foreach (frm[i]) begin
            if (i == gap_at) begin
                dv = 1'b0;
                @(posedge clk); #1;
            end
            dv = 1'b1;
            rxd = frm[i];
            @(posedge clk); #1;
            if (timed && i == 49) chk("en_before_payload", i, rec_en, 1'b0);
            if (timed && i == 50) chk("first_strobe", i, {rec_en, rec_data}, {1'b1, pay[0]});
            if (timed && i == 59) chk("done_early", i, rec_pkt_done, 1'b0);
            if (timed && i == 60) chk("done_timing", i, {rec_pkt_done, rec_byte_num}, {1'b1, 16'd10});
        end
        dv = 1'b0;
        rxd = 8'd0;
        repeat (12) begin @(posedge clk); #1; end
    endtask

    task automatic run(input vec_t v, input int idx, input int gap_at, input bit timed);
        logic [47:0] smac;
        logic [31:0] sip;
        smac = v.seq ? BMAC : {16'($urandom), 32'($urandom)};
        sip  = v.seq ? BIP : 32'($urandom);
        build(v, smac, sip);
        got_q.delete();
        done_n = 0;
        send(gap_at, timed);
        if (v.exp_done) begin
            exp_smac = smac;
            exp_sip  = sip;
        end
        last_num = v.exp_num;
        chk("strobes", idx, got_q.size(), v.exp_en);
        for (int i = 0; i < got_q.size() && i < v.exp_en; i++) chk("data", idx, got_q[i], pay[i]);
        chk("done_pulses", idx, done_n, v.exp_done ? 1 : 0);
        chk("byte_num", idx, rec_byte_num, v.exp_num);
        chk("src_ip", idx, src_ip, exp_sip);
        chk("src_mac", idx, src_mac, exp_smac);
    endtask

    initial begin
        vec_t v;
        int   r, p;
        tbl[0]  = '{BMAC, 16'h0800, 8'd17, BIP, 16'd18, 10, -1, 1'b0, 1'b1, 10, 1'b1, 16'd10};
        tbl[1]  = '{48'hffff_ffff_ffff, 16'h0800, 8'd17, BIP, 16'd38, 30, -1, 1'b0, 1'b0, 30, 1'b1, 16'd30};
        tbl[2]  = '{48'hffff_ffff_ffff, 16'h0800, 8'd17, BIP, 16'd38, 30, -1, 1'b0, 1'b0, 30, 1'b1, 16'd30};
        tbl[3]  = '{BMAC, 16'h0800, 8'd17, {8'd192, 8'd168, 8'd1, 8'd99}, 16'd18, 10, -1, 1'b0, 1'b0, 0, 1'b0, 16'd30};
        tbl[4]  = '{BMAC, 16'h0806, 8'd17, BIP, 16'd18, 10, -1, 1'b0, 1'b0, 0, 1'b0, 16'd30};
        tbl[5]  = '{BMAC, 16'h0800, 8'd17, BIP, 16'd8, 18, -1, 1'b0, 1'b0, 0, 1'b1, 16'd0};
        tbl[6]  = '{BMAC, 16'h0800, 8'd17, BIP, 16'd18, 10, 4, 1'b0, 1'b0, 4, 1'b0, 16'd0};
        tbl[7]  = '{BMAC, 16'h0800, 8'd17, BIP, 16'd18, 10, -1, 1'b0, 1'b0, 10, 1'b1, 16'd10};
`ifdef UDP_RX_IP_CSUM_EN
        tbl[8]  = '{BMAC, 16'h0800, 8'd17, BIP, 16'd18, 10, -1, 1'b1, 1'b0, 0, 1'b0, 16'd10};
`else
        tbl[8]  = '{BMAC, 16'h0800, 8'd17, BIP, 16'd18, 10, -1, 1'b1, 1'b0, 10, 1'b1, 16'd10};
`endif
        tbl[9]  = '{BMAC, 16'h0800, 8'd17, BIP, 16'd18, 10, -1, 1'b0, 1'b0, 10, 1'b1, 16'd10};
        tbl[10] = '{BMAC, 16'h0800, 8'd17, BIP, 16'd5, 10, -1, 1'b0, 1'b0, 0, 1'b0, 16'd10};
        tbl[11] = '{48'h00_11_22_33_44_56, 16'h0800, 8'd17, BIP, 16'd18, 10, -1, 1'b0, 1'b0, 0, 1'b0, 16'd10};
        tbl[12] = '{BMAC, 16'h0800, 8'd6, BIP, 16'd18, 10, -1, 1'b0, 1'b0, 0, 1'b0, 16'd10};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 0, {rec_en, rec_data, rec_pkt_done, rec_byte_num}, 64'd0);
        chk("reset_src", 0, {src_mac, src_ip[15:0]}, 64'd0);
        chk("reset_src_ip_hi", 0, src_ip[31:16], 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) run(tbl[i], i, -1, 1'b0);

        // Latency of first strobe and done pulse on a clean 10-byte frame
        v = tbl[7];
        run(v, 100, -1, 1'b1);
        // One idle cycle inside the Ethernet header ends the frame
        v = tbl[7];
        v.exp_en = 0;
        v.exp_done = 1'b0;
        v.exp_num = last_num;
        run(v, 101, 20, 1'b0);
        // One idle cycle inside the payload: strobes so far stay, no done
        v = tbl[7];
        v.exp_en = 3;
        v.exp_done = 1'b0;
        v.exp_num = last_num;
        run(v, 102, 53, 1'b0);
        v = tbl[9];
        run(v, 103, -1, 1'b1);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 5);
            v.dmac  = (r < 3) ? BMAC : (r < 5) ? 48'hffff_ffff_ffff : {16'($urandom), 32'($urandom)};
            v.etype = ($urandom_range(0, 7) == 0) ? 16'h0806 : 16'h0800;
            v.proto = ($urandom_range(0, 7) == 0) ? 8'd6 : 8'd17;
            v.dip   = ($urandom_range(0, 7) == 0) ? 32'($urandom) : BIP;
            v.ulen  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom_range(8, 40));
            p = (v.ulen >= 16'd8) ? int'(v.ulen) - 8 : 0;
            v.npay  = p + int'($urandom_range(0, 6));
            v.cut   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, p)) : -1;
            v.bad_csum = ($urandom_range(0, 7) == 0);
            v.seq   = 1'b0;
            model(v);
            run(v, 200 + n, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
